// File: rtl/input_cond_pkg.sv
// Shared constants for the board input conditioner: debounce timing, KEY/SW bit layout
// and the packing of clean levels and pending flags into the 32-bit PIO_IN word.
package input_cond_pkg;

   localparam int DEBOUNCE_10MS_25MHZ = 250000;
   localparam int GPIO_CLEAN_LSB      = 0;
   localparam int GPIO_PEND_LSB       = 16;
   localparam int KEY_LSB             = 0;
   localparam int SW_LSB              = 4;
   localparam int N_KEY               = SW_LSB - KEY_LSB;
   localparam int N_SW                = 10;

   // KEYs idle high; switches report events on their rising edge.
   localparam logic [15:0] KEY_MASK = 16'(((1 << N_KEY) - 1) << KEY_LSB);
   localparam logic [15:0] SW_MASK  = 16'(((1 << N_SW) - 1) << SW_LSB);

   function automatic logic [31:0] pack_gpio(input logic [15:0] clean,
                                             input logic [15:0] pending);
      logic [31:0] word;
      word = '0;
      word[GPIO_CLEAN_LSB +: 16] = clean;
      word[GPIO_PEND_LSB  +: 16] = pending;
      return word;
   endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One input: synchroniser chain, stability counter, accepted clean level and
// registered rise/fall pulses, plus same-cycle accept strobes for event logic.
module debounce_bit #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 250000,
   parameter int   CNT_W           = 18,
   parameter logic RST_VAL         = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall,
   output logic rise_next,
   output logic fall_next
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   s;
   logic                   accept;

   assign s = sync[SYNC_STAGES-1];

   // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
   always_comb begin
      accept    = (s != clean) && (cnt == CNT_MAX);
      rise_next = accept && s;
      fall_next = accept && !s;
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync  <= {SYNC_STAGES{RST_VAL}};
         clean <= RST_VAL;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
         rise <= rise_next;
         fall <= fall_next;
         if (s == clean) begin
            cnt <= '0;
         end else if (accept) begin
            clean <= s;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Debounces the KEY/SW pins in the clk25 domain and presents clean levels, edge pulses,
// sticky event flags and the packed PIO_IN word for software.
module input_conditioner
   import input_cond_pkg::*;
#(
   parameter int              N_IN            = 14,
   parameter int              SYNC_STAGES     = 2,
   parameter int              DEBOUNCE_CYCLES = DEBOUNCE_10MS_25MHZ,
   parameter int              CNT_W           = 18,
   parameter logic [N_IN-1:0] RST_LEVEL       = N_IN'(KEY_MASK),
   parameter logic [N_IN-1:0] PEND_ON_RISE    = N_IN'(SW_MASK)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_IN-1:0] raw_i,
   input  logic [N_IN-1:0] ev_clear_i,
   output logic [N_IN-1:0] clean_o,
   output logic [N_IN-1:0] rise_o,
   output logic [N_IN-1:0] fall_o,
   output logic [N_IN-1:0] pending_o,
   output logic [31:0]     gpio_word_o
);

   logic [N_IN-1:0] rise_next;
   logic [N_IN-1:0] fall_next;

   for (genvar i = 0; i < N_IN; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W),
         .RST_VAL        (RST_LEVEL[i])
      ) u_debounce (
         .clk      (clk),
         .reset_n  (reset_n),
         .raw      (raw_i[i]),
         .clean    (clean_o[i]),
         .rise     (rise_o[i]),
         .fall     (fall_o[i]),
         .rise_next(rise_next[i]),
         .fall_next(fall_next[i])
      );
   end

   // Pending is set in the same edge that changes clean; a set beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_o <= '0;
      end else begin
         pending_o <= (pending_o & ~ev_clear_i)
                    | (rise_next &  PEND_ON_RISE)
                    | (fall_next & ~PEND_ON_RISE);
      end
   end

   assign gpio_word_o = pack_gpio(16'(clean_o), 16'(pending_o));

endmodule

// File: tb/tb_input_conditioner.sv
// Randomised and directed bench for input_conditioner with a short debounce window,
// checked every cycle against a queue-based behavioural model.
module tb_input_conditioner;

   localparam int N    = 14;
   localparam int SYNC = 2;
   localparam int D    = 8;
   localparam logic [N-1:0] RST_LEVEL    = 14'h000F;
   localparam logic [N-1:0] PEND_ON_RISE = 14'h3FF0;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [N-1:0]  raw_i;
   logic [N-1:0]  ev_clear_i;
   logic [N-1:0]  clean_o, rise_o, fall_o, pending_o;
   logic [31:0]   gpio_word_o;

   int n_checks = 0;
   int n_fail   = 0;

   input_conditioner #(
      .N_IN           (N),
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw_i      (raw_i),
      .ev_clear_i (ev_clear_i),
      .clean_o    (clean_o),
      .rise_o     (rise_o),
      .fall_o     (fall_o),
      .pending_o  (pending_o),
      .gpio_word_o(gpio_word_o)
   );

   always #20 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: s is raw delayed SYNC edges; a bit flips once the last D
   // samples of s all differ from the current clean level.
   logic [N-1:0] pipe_q[$];
   logic [N-1:0] s_q[$];
   logic [N-1:0] m_clean, m_rise, m_fall, m_pend;
   bit           model_valid = 0;

   task automatic model_step();
      logic [N-1:0] s;
      logic [N-1:0] accept;
      if (!reset_n) begin
         pipe_q.delete();
         s_q.delete();
         for (int i = 0; i < SYNC; i++) pipe_q.push_back(RST_LEVEL);
         m_clean = RST_LEVEL;
         m_rise = '0; m_fall = '0; m_pend = '0;
         model_valid = 1;
         return;
      end
      if (!model_valid) return;
      s = pipe_q.pop_front();
      pipe_q.push_back(raw_i);
      s_q.push_back(s);
      if (s_q.size() > D) void'(s_q.pop_front());
      accept = '0;
      if (s_q.size() == D) begin
         accept = '1;
         foreach (s_q[k]) accept &= (s_q[k] ^ m_clean);
      end
      m_rise  = accept & s;
      m_fall  = accept & ~s;
      m_clean = m_clean ^ accept;
      m_pend  = (m_pend & ~ev_clear_i) | (m_rise & PEND_ON_RISE) | (m_fall & ~PEND_ON_RISE);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (model_valid) begin
         check("clean",   32'(clean_o),   32'(m_clean));
         check("rise",    32'(rise_o),    32'(m_rise));
         check("fall",    32'(fall_o),    32'(m_fall));
         check("pending", 32'(pending_o), 32'(m_pend));
         check("gpio",    gpio_word_o,    {2'b0, m_pend, 2'b0, m_clean});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit fall_seen, rise_seen, pend_seen;

      // 1. reset
      reset_n    = 1'b0;
      raw_i      = 14'h000F;
      ev_clear_i = '0;
      tick(); tick();
      check("rst_clean",   32'(clean_o),   32'h0000_000F);
      check("rst_pending", 32'(pending_o), 32'h0);
      check("rst_rise",    32'(rise_o),    32'h0);
      check("rst_fall",    32'(fall_o),    32'h0);
      check("rst_gpio",    gpio_word_o,    32'h0000_000F);
      reset_n = 1'b1;
      tick();

      // 2. switch 0 rises: accepted on the 10th edge
      raw_i[4] = 1'b1;
      repeat (9) tick();
      check("t2_not_yet", 32'(clean_o[4]), 32'h0);
      tick();
      check("t2_clean", 32'(clean_o[4]),   32'h1);
      check("t2_rise",  32'(rise_o[4]),    32'h1);
      check("t2_pend",  32'(pending_o[4]), 32'h1);
      check("t2_gpio",  gpio_word_o,       32'h0010_001F);
      tick();
      check("t2_rise_end", 32'(rise_o[4]), 32'h0);

      // 3. short bounce on KEY1 is rejected
      raw_i[1] = 1'b0;
      repeat (5) tick();
      raw_i[1] = 1'b1;
      fall_seen = 0;
      repeat (15) begin
         tick();
         fall_seen |= fall_o[1];
      end
      check("t3_clean", 32'(clean_o[1]),   32'h1);
      check("t3_fall",  32'(fall_seen),    32'h0);
      check("t3_pend",  32'(pending_o[1]), 32'h0);

      // 4. held press on KEY1, then clear the flag
      raw_i[1] = 1'b0;
      repeat (10) tick();
      check("t4_clean", 32'(clean_o[1]),   32'h0);
      check("t4_fall",  32'(fall_o[1]),    32'h1);
      check("t4_pend",  32'(pending_o[1]), 32'h1);
      tick();
      check("t4_fall_end", 32'(fall_o[1]), 32'h0);
      ev_clear_i[1] = 1'b1;
      tick();
      ev_clear_i[1] = 1'b0;
      check("t4_cleared", 32'(pending_o[1]), 32'h0);
      raw_i[1] = 1'b1;
      repeat (12) tick();
      check("t4_release_clean", 32'(clean_o[1]),   32'h1);
      check("t4_release_pend",  32'(pending_o[1]), 32'h0);

      // 5. clear coincident with the setting edge: set wins
      raw_i[2] = 1'b0;
      repeat (9) tick();
      ev_clear_i[2] = 1'b1;
      tick();
      ev_clear_i[2] = 1'b0;
      check("t5_fall", 32'(fall_o[2]),    32'h1);
      check("t5_pend", 32'(pending_o[2]), 32'h1);
      raw_i[2] = 1'b1;
      repeat (12) tick();

      // 6. reset mid-count discards the partial count
      raw_i[5] = 1'b1;
      rise_seen = 0; pend_seen = 0;
      repeat (5) begin
         tick();
         rise_seen |= rise_o[5];
         pend_seen |= pending_o[5];
      end
      reset_n = 1'b0;
      tick();
      reset_n  = 1'b1;
      raw_i[5] = 1'b0;
      repeat (15) begin
         tick();
         rise_seen |= rise_o[5];
         pend_seen |= pending_o[5];
      end
      check("t6_clean", 32'(clean_o[5]), 32'h0);
      check("t6_rise",  32'(rise_seen),  32'h0);
      check("t6_pend",  32'(pend_seen),  32'h0);

      // Random phase: sparse toggles give a mix of bounces and accepted steps.
      repeat (3000) begin
         tick();
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 29) == 0) raw_i[i] = ~raw_i[i];
         ev_clear_i = N'($urandom) & N'($urandom) & N'($urandom);
         reset_n    = ($urandom_range(0, 699) != 0);
      end
      reset_n    = 1'b1;
      ev_clear_i = '0;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
